// File: rtl/arm9_ram_arbiter_if.sv
// Bus bundle between the two RAM masters (CPU data port, DMA/debug loader), the arbiter
// and the single-port data RAM.
interface arm9_ram_arbiter_if #(
  parameter int unsigned AW = 13
);
  logic        cpu_cen;
  logic        cpu_wen;
  logic [3:0]  cpu_flag;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_hold;

  logic        dma_req;
  logic        dma_wen;
  logic [3:0]  dma_flag;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;

  logic          mem_cen;
  logic          mem_wen;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  // Environment side: both requesters plus the RAM read port.
  modport master (
    output cpu_cen, cpu_wen, cpu_flag, cpu_addr, cpu_wdata,
    output dma_req, dma_wen, dma_flag, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_hold, dma_gnt, dma_rvalid, dma_rdata,
    input  mem_cen, mem_wen, mem_be, mem_addr, mem_wdata
  );

  // Arbiter side.
  modport slave (
    input  cpu_cen, cpu_wen, cpu_flag, cpu_addr, cpu_wdata,
    input  dma_req, dma_wen, dma_flag, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_hold, dma_gnt, dma_rvalid, dma_rdata,
    output mem_cen, mem_wen, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/arm9_ram_arbiter.sv
// Fixed-priority CPU / DMA arbiter for the single-port data RAM, with a starvation counter
// that inserts a one-cycle CPU hold so the DMA master always makes progress.
module arm9_ram_arbiter #(
  parameter int unsigned AW         = 13,
  parameter int unsigned STARVE_MAX = 16
) (
  input logic              clk,
  input logic              rst,
  arm9_ram_arbiter_if.slave bus
);
  typedef enum logic {StRun = 1'b0, StHold = 1'b1} state_t;

  localparam logic [7:0] CntLast = 8'(STARVE_MAX - 1);

  state_t      state_q, state_d;
  logic [7:0]  starve_cnt, starve_cnt_d;
  logic        cpu_rd_d;
  logic        dma_rvalid;
  logic [31:0] cpu_rdata_q;

  logic cpu_sel, cpu_win, dma_gnt, cpu_hold, starving;

  assign cpu_hold = (state_q == StHold);
  assign cpu_sel  = bus.cpu_cen & (bus.cpu_addr[31:28] == 4'h4);
  // Grants are gated by rst so every combinational output is quiet during reset.
  assign cpu_win  = cpu_sel & ~cpu_hold & ~rst;
  assign dma_gnt  = bus.dma_req & ~cpu_win & ~rst;
  assign starving = bus.dma_req & ~dma_gnt;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = 8'd0;
    case (state_q)
      StRun: begin
        if (starving) begin
          if (starve_cnt == CntLast) begin
            state_d = StHold;
          end else begin
            starve_cnt_d = starve_cnt + 8'd1;
          end
        end
      end
      StHold:  state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      starve_cnt  <= 8'd0;
      cpu_rd_d    <= 1'b0;
      dma_rvalid  <= 1'b0;
      cpu_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      starve_cnt <= starve_cnt_d;
      cpu_rd_d   <= cpu_win & ~bus.cpu_wen;
      dma_rvalid <= dma_gnt & ~bus.dma_wen;
      if (cpu_rd_d) begin
        cpu_rdata_q <= bus.mem_rdata;
      end
    end
  end

  always_comb begin
    bus.mem_cen   = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.mem_be    = 4'h0;
    bus.mem_addr  = '0;
    bus.mem_wdata = 32'd0;
    if (cpu_win) begin
      bus.mem_cen   = 1'b1;
      bus.mem_wen   = bus.cpu_wen;
      bus.mem_be    = bus.cpu_wen ? bus.cpu_flag : 4'hF;
      bus.mem_addr  = bus.cpu_addr[AW+1:2];
      bus.mem_wdata = bus.cpu_wdata;
    end else if (dma_gnt) begin
      bus.mem_cen   = 1'b1;
      bus.mem_wen   = bus.dma_wen;
      bus.mem_be    = bus.dma_wen ? bus.dma_flag : 4'hF;
      bus.mem_addr  = bus.dma_addr[AW+1:2];
      bus.mem_wdata = bus.dma_wdata;
    end
  end

  // Read data stays stable across hold and non-RAM cycles.
  assign bus.cpu_rdata  = cpu_rd_d ? bus.mem_rdata : cpu_rdata_q;
  assign bus.dma_rdata  = dma_rvalid ? bus.mem_rdata : 32'd0;
  assign bus.dma_rvalid = dma_rvalid;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.cpu_hold   = cpu_hold;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.cpu_addr[27:AW+2], bus.cpu_addr[1:0],
                              bus.dma_addr[31:AW+2], bus.dma_addr[1:0]};
endmodule
